// File: rtl/sor_bank.sv
// Bank of NCH special-operand pointer registers. Each pointer is loaded from the C-bus,
// steps by STEP with optional wrap at a per-channel limit, and is read out over the A-bus.
module sor_bank #(
   parameter int               WIDTH      = 32,
   parameter int               NCH        = 2,
   parameter logic [WIDTH-1:0] STEP       = 1,
   parameter logic [3:0]       DATA_CODE  = 4'd9,
   parameter logic [3:0]       LIMIT_CODE = 4'd11,
   parameter logic [2:0]       ABUS_CODE  = 3'd4
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [WIDTH-1:0] cbus_out,
   input  logic [3:0]       cbus_en,
   input  logic [2:0]       abus_en,
   input  logic [NCH-1:0]   inc_en,
   output logic [WIDTH-1:0] abus_in,
   output logic [NCH-1:0]   wrap
);

   localparam int DataLast  = int'(DATA_CODE) + NCH - 1;
   localparam int LimitLast = int'(LIMIT_CODE) + NCH - 1;
   localparam int AbusLast  = int'(ABUS_CODE) + NCH - 1;

   // Code ranges are derived from the base codes, so they must fit and stay disjoint.
   if (NCH < 1 || NCH > 8) begin : g_badNch
      $error("sor_bank: NCH must be in 1..8");
   end
   if (DataLast > 15 || LimitLast > 15 || AbusLast > 7) begin : g_badRange
      $error("sor_bank: code range exceeds bus-enable code space");
   end
   if (!(DataLast < int'(LIMIT_CODE) || LimitLast < int'(DATA_CODE))) begin : g_badOverlap
      $error("sor_bank: DATA and LIMIT code ranges overlap");
   end

   logic [WIDTH-1:0] w_data [NCH];

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      localparam logic [3:0] DataCode  = DATA_CODE + 4'(i);
      localparam logic [3:0] LimitCode = LIMIT_CODE + 4'(i);

      logic [WIDTH-1:0] r_data;
      logic [WIDTH-1:0] r_limit;
      logic             r_wrap;
      logic [WIDTH:0]   w_sum;
      logic [WIDTH-1:0] w_next;
      logic             w_wrapNext;

      assign w_sum = {1'b0, r_data} + {1'b0, STEP};

      // A single subtraction folds the sum back below the limit; limit 0 means free-running.
      always_comb begin
         w_next     = w_sum[WIDTH-1:0];
         w_wrapNext = 1'b0;
         if (r_limit == '0) begin
            w_wrapNext = w_sum[WIDTH];
         end else if (w_sum >= {1'b0, r_limit}) begin
            w_next     = r_data + STEP - r_limit;
            w_wrapNext = 1'b1;
         end
      end

      always_ff @(negedge clock) begin
         if (!rst) begin
            r_data  <= '0;
            r_limit <= '0;
            r_wrap  <= 1'b0;
         end else begin
            if (cbus_en == LimitCode) begin
               r_limit <= cbus_out;
            end
            if (cbus_en == DataCode) begin
               r_data <= cbus_out;
               r_wrap <= 1'b0;
            end else if (inc_en[i]) begin
               r_data <= w_next;
               r_wrap <= w_wrapNext;
            end else begin
               r_wrap <= 1'b0;
            end
         end
      end

      assign w_data[i] = r_data;
      assign wrap[i]   = r_wrap;
   end

   always_comb begin
      abus_in = '0;
      for (int i = 0; i < NCH; i++) begin
         if (abus_en == ABUS_CODE + 3'(i)) begin
            abus_in = w_data[i];
         end
      end
   end

endmodule

// File: tb/tb_sor_bank.sv
// Directed bench for sor_bank: each scenario task drives the bank on the falling-edge
// schedule and compares A-bus/wrap against hand-computed values.
module tb_sor_bank;

   logic        clock;
   logic        rst;
   logic [31:0] cbus_out;
   logic [3:0]  cbus_en;
   logic [2:0]  abus_en;
   logic [1:0]  inc_en;
   logic [31:0] abus_in;
   logic [1:0]  wrap;

   int testsRun    = 0;
   int testsFailed = 0;

   sor_bank dut (
      .clock    (clock),
      .rst      (rst),
      .cbus_out (cbus_out),
      .cbus_en  (cbus_en),
      .abus_en  (abus_en),
      .inc_en   (inc_en),
      .abus_in  (abus_in),
      .wrap     (wrap)
   );

   initial clock = 1'b1;
   always #5 clock = ~clock;

   // Advance one falling edge, then settle so outputs are sampled away from the edge.
   task tick();
      @(negedge clock);
      #1;
   endtask

   task idle();
      cbus_en  = 4'd0;
      cbus_out = 32'h0;
      inc_en   = 2'b00;
   endtask

   task test_reset();
      rst = 1'b1;
      cbus_en = 4'd9;  cbus_out = 32'd5; tick();
      abus_en = 3'd4; #1;
      testsRun++;
      if (abus_in !== 32'd5) begin
         testsFailed++;
         $display("[TB] FAIL reset_preload: abus_in=%h expected %h", abus_in, 32'd5);
      end
      cbus_en = 4'd11; cbus_out = 32'd7; tick();
      rst = 1'b0; cbus_en = 4'd9; cbus_out = 32'h55; inc_en = 2'b11; tick();
      rst = 1'b1; idle(); #1;
      testsRun++;
      if (abus_in !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_data0: abus_in=%h expected %h", abus_in, 32'd0);
      end
      abus_en = 3'd5; #1;
      testsRun++;
      if (abus_in !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_data1: abus_in=%h expected %h", abus_in, 32'd0);
      end
      testsRun++;
      if (wrap !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL reset_wrap: wrap=%b expected %b", wrap, 2'b00);
      end
      // limit0 must be 0 again: 6 -> 7 without wrapping (limit 7 would give 0 and a wrap)
      abus_en = 3'd4;
      cbus_en = 4'd9; cbus_out = 32'd6; tick();
      idle(); inc_en = 2'b01; tick();
      idle(); #1;
      testsRun++;
      if (abus_in !== 32'd7 || wrap !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL reset_limit: abus_in=%h wrap=%b expected %h wrap %b",
                  abus_in, wrap, 32'd7, 2'b00);
      end
   endtask

   task test_load_step();
      abus_en = 3'd4;
      cbus_en = 4'd9; cbus_out = 32'h10; tick();
      idle(); #1;
      testsRun++;
      if (abus_in !== 32'h10) begin
         testsFailed++;
         $display("[TB] FAIL load_data0: abus_in=%h expected %h", abus_in, 32'h10);
      end
      for (int k = 0; k < 3; k++) begin
         inc_en = 2'b01; tick();
         testsRun++;
         if (wrap !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL step_nowrap%0d: wrap=%b expected %b", k, wrap, 2'b00);
         end
      end
      idle(); #1;
      testsRun++;
      if (abus_in !== 32'h13) begin
         testsFailed++;
         $display("[TB] FAIL step_data0: abus_in=%h expected %h", abus_in, 32'h13);
      end
      abus_en = 3'd5; #1;
      testsRun++;
      if (abus_in !== 32'h0) begin
         testsFailed++;
         $display("[TB] FAIL step_ch1_untouched: abus_in=%h expected %h", abus_in, 32'h0);
      end
   endtask

   task test_modulo_wrap();
      logic [31:0] expData [3];
      logic [1:0]  expWrap [3];
      expData = '{32'd3, 32'd0, 32'd1};
      expWrap = '{2'b00, 2'b10, 2'b00};
      abus_en = 3'd5;
      cbus_en = 4'd12; cbus_out = 32'd4; tick();
      cbus_en = 4'd10; cbus_out = 32'd2; tick();
      idle();
      for (int k = 0; k < 3; k++) begin
         inc_en = 2'b10; tick();
         testsRun++;
         if (abus_in !== expData[k] || wrap !== expWrap[k]) begin
            testsFailed++;
            $display("[TB] FAIL modulo_step%0d: data1=%h wrap=%b expected %h wrap %b",
                     k, abus_in, wrap, expData[k], expWrap[k]);
         end
      end
      idle(); tick();
      testsRun++;
      if (abus_in !== 32'd1 || wrap !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL modulo_hold: data1=%h wrap=%b expected %h wrap %b",
                  abus_in, wrap, 32'd1, 2'b00);
      end
   endtask

   task test_overflow();
      abus_en = 3'd4;
      cbus_en = 4'd11; cbus_out = 32'd0; tick();
      cbus_en = 4'd9;  cbus_out = 32'hFFFF_FFFF; tick();
      idle(); inc_en = 2'b01; tick();
      testsRun++;
      if (abus_in !== 32'd0 || wrap !== 2'b01) begin
         testsFailed++;
         $display("[TB] FAIL overflow_step: data0=%h wrap=%b expected %h wrap %b",
                  abus_in, wrap, 32'd0, 2'b01);
      end
      idle(); tick();
      testsRun++;
      if (abus_in !== 32'd0 || wrap !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL overflow_pulse: data0=%h wrap=%b expected %h wrap %b",
                  abus_in, wrap, 32'd0, 2'b00);
      end
   endtask

   task test_simultaneous();
      abus_en = 3'd4;
      cbus_en = 4'd9; cbus_out = 32'h20; inc_en = 2'b01; tick();
      testsRun++;
      if (abus_in !== 32'h20 || wrap !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL load_beats_step: data0=%h wrap=%b expected %h wrap %b",
                  abus_in, wrap, 32'h20, 2'b00);
      end
      cbus_en = 4'd9; cbus_out = 32'd2; inc_en = 2'b00; tick();
      cbus_en = 4'd11; cbus_out = 32'd3; inc_en = 2'b01; tick();
      testsRun++;
      if (abus_in !== 32'd3 || wrap !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL old_limit_step: data0=%h wrap=%b expected %h wrap %b",
                  abus_in, wrap, 32'd3, 2'b00);
      end
      idle(); inc_en = 2'b01; tick();
      testsRun++;
      if (abus_in !== 32'd1 || wrap !== 2'b01) begin
         testsFailed++;
         $display("[TB] FAIL new_limit_step: data0=%h wrap=%b expected %h wrap %b",
                  abus_in, wrap, 32'd1, 2'b01);
      end
      inc_en = 2'b11; tick();
      abus_en = 3'd4; #1;
      testsRun++;
      if (abus_in !== 32'd2 || wrap !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL dual_step_ch0: data0=%h wrap=%b expected %h wrap %b",
                  abus_in, wrap, 32'd2, 2'b00);
      end
      abus_en = 3'd5; #1;
      testsRun++;
      if (abus_in !== 32'd2) begin
         testsFailed++;
         $display("[TB] FAIL dual_step_ch1: data1=%h expected %h", abus_in, 32'd2);
      end
      // data loaded above limit 4: one subtraction only, 10+1-4 = 7
      cbus_en = 4'd10; cbus_out = 32'd10; inc_en = 2'b00; tick();
      idle(); inc_en = 2'b10; tick();
      testsRun++;
      if (abus_in !== 32'd7 || wrap !== 2'b10) begin
         testsFailed++;
         $display("[TB] FAIL single_subtract: data1=%h wrap=%b expected %h wrap %b",
                  abus_in, wrap, 32'd7, 2'b10);
      end
      idle(); tick();
   endtask

   task test_abus_decode();
      logic [2:0]  codes   [5];
      logic [31:0] expBus  [5];
      codes  = '{3'd5, 3'd4, 3'd0, 3'd7, 3'd6};
      expBus = '{32'd7, 32'd2, 32'd0, 32'd0, 32'd0};
      for (int k = 0; k < 5; k++) begin
         abus_en = codes[k]; #1;
         testsRun++;
         if (abus_in !== expBus[k]) begin
            testsFailed++;
            $display("[TB] FAIL abus_code%0d: abus_in=%h expected %h",
                     codes[k], abus_in, expBus[k]);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      abus_en = 3'd0;
      idle();
      tick();
      tick();
      test_reset();
      test_load_step();
      test_modulo_wrap();
      test_overflow();
      test_simultaneous();
      test_abus_decode();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
